// File: rtl/ram_bus_ctrl_if.sv
// Bus bundle between a 68000-style CPU bus, the RAM controller and two byte-wide RAM banks.
// The master modport is the CPU/RAM side; the controller takes the slave modport.
interface ram_bus_ctrl_if #(
  parameter int ADDRESS_WIDTH = 14
);
  logic                     cpu_as;
  logic                     cpu_rw;
  logic                     cpu_uds;
  logic                     cpu_lds;
  logic [22:0]              cpu_addr;
  logic [15:0]              cpu_dout;
  logic [15:0]              cpu_din;
  logic                     cpu_dtack;
  logic                     cpu_berr;
  logic                     ram_cs;
  logic                     ram_we_u;
  logic                     ram_we_l;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [15:0]              ram_din;
  logic [15:0]              ram_q;

  modport master (
    output cpu_as, cpu_rw, cpu_uds, cpu_lds, cpu_addr, cpu_dout, ram_q,
    input  cpu_din, cpu_dtack, cpu_berr, ram_cs, ram_we_u, ram_we_l, ram_addr, ram_din
  );

  modport slave (
    input  cpu_as, cpu_rw, cpu_uds, cpu_lds, cpu_addr, cpu_dout, ram_q,
    output cpu_din, cpu_dtack, cpu_berr, ram_cs, ram_we_u, ram_we_l, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_bus_ctrl.sv
// Bridges an asynchronous CPU bus cycle onto two synchronous byte-wide RAM banks.
// Accesses outside the RAM window end with a bus error and never touch the RAM.
module ram_bus_ctrl #(
  parameter logic [23:0] BASE_ADDR     = 24'h000000,
  parameter int          DEPTH         = 16384,
  parameter int          ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           reset,
  ram_bus_ctrl_if.slave bus
);
  localparam logic [24:0] WINDOW_BYTES = 25'(2 * DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, ERR} state_t;

  state_t                   r_state;
  logic                     r_rw;
  logic [15:0]              r_cpuDin;
  logic                     r_dtack;
  logic                     r_berr;
  logic                     r_ramCs;
  logic                     r_ramWeU;
  logic                     r_ramWeL;
  logic [ADDRESS_WIDTH-1:0] r_ramAddr;
  logic [15:0]              r_ramDin;

  logic [23:0]              w_offset;
  logic                     w_inWindow;

  // Addresses below the base wrap to huge offsets and so fall outside the window.
  assign w_offset   = {bus.cpu_addr, 1'b0} - BASE_ADDR;
  assign w_inWindow = {1'b0, w_offset} < WINDOW_BYTES;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rw      <= 1'b0;
      r_cpuDin  <= '0;
      r_dtack   <= 1'b0;
      r_berr    <= 1'b0;
      r_ramCs   <= 1'b0;
      r_ramWeU  <= 1'b0;
      r_ramWeL  <= 1'b0;
      r_ramAddr <= '0;
      r_ramDin  <= '0;
    end else begin
      r_ramCs  <= 1'b0;
      r_ramWeU <= 1'b0;
      r_ramWeL <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cpu_as) begin
            r_rw      <= bus.cpu_rw;
            r_ramDin  <= bus.cpu_dout;
            r_ramAddr <= w_offset[ADDRESS_WIDTH:1];
            // RAM strobes are set on entry so they are high exactly while in ISSUE.
            if (w_inWindow) begin
              r_state  <= ISSUE;
              r_ramCs  <= 1'b1;
              r_ramWeU <= ~bus.cpu_rw & bus.cpu_uds;
              r_ramWeL <= ~bus.cpu_rw & bus.cpu_lds;
            end else begin
              r_state <= ERR;
            end
          end
        end
        ISSUE: begin
          r_state <= r_rw ? WAIT : ACK;
        end
        WAIT: begin
          r_cpuDin <= bus.ram_q;
          r_state  <= ACK;
        end
        ACK: begin
          if (!bus.cpu_as) begin
            r_dtack <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_dtack <= 1'b1;
          end
        end
        ERR: begin
          if (!bus.cpu_as) begin
            r_berr  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_berr <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_din   = r_cpuDin;
  assign bus.cpu_dtack = r_dtack;
  assign bus.cpu_berr  = r_berr;
  assign bus.ram_cs    = r_ramCs;
  assign bus.ram_we_u  = r_ramWeU;
  assign bus.ram_we_l  = r_ramWeL;
  assign bus.ram_addr  = r_ramAddr;
  assign bus.ram_din   = r_ramDin;
endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Drives identical CPU bus cycles into two controllers with different RAM windows and
// checks each against a word-array model of the CPU-visible memory and the cycle timing.
module tb_ram_bus_ctrl;
  localparam int          DEPTH = 16384;
  localparam int          AW    = 14;
  localparam logic [23:0] BASE0 = 24'h000000;
  localparam logic [23:0] BASE1 = 24'h100000;
  localparam int          NONE  = 99;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  logic [7:0]  bankU0 [DEPTH];
  logic [7:0]  bankL0 [DEPTH];
  logic [7:0]  bankU1 [DEPTH];
  logic [7:0]  bankL1 [DEPTH];
  logic [15:0] refMem [2][DEPTH];
  logic [15:0] lastDin [2];

  always #5 clk = ~clk;

  ram_bus_ctrl_if #(.ADDRESS_WIDTH(AW)) bus0 ();
  ram_bus_ctrl_if #(.ADDRESS_WIDTH(AW)) bus1 ();

  ram_bus_ctrl #(.BASE_ADDR(BASE0), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  ram_bus_ctrl #(.BASE_ADDR(BASE1), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Synchronous RAM banks: data appears one clock after the selected address edge.
  always @(posedge clk) begin
    if (bus0.ram_cs) begin
      if (bus0.ram_we_u) bankU0[bus0.ram_addr] <= bus0.ram_din[15:8];
      if (bus0.ram_we_l) bankL0[bus0.ram_addr] <= bus0.ram_din[7:0];
      bus0.ram_q <= {bankU0[bus0.ram_addr], bankL0[bus0.ram_addr]};
    end
    if (bus1.ram_cs) begin
      if (bus1.ram_we_u) bankU1[bus1.ram_addr] <= bus1.ram_din[15:8];
      if (bus1.ram_we_l) bankL1[bus1.ram_addr] <= bus1.ram_din[7:0];
      bus1.ram_q <= {bankU1[bus1.ram_addr], bankL1[bus1.ram_addr]};
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic setCpu(input logic as, input logic rw, input logic uds, input logic lds,
                        input logic [22:0] addr, input logic [15:0] data);
    bus0.cpu_as = as;  bus0.cpu_rw = rw;  bus0.cpu_uds = uds;  bus0.cpu_lds = lds;
    bus0.cpu_addr = addr;  bus0.cpu_dout = data;
    bus1.cpu_as = as;  bus1.cpu_rw = rw;  bus1.cpu_uds = uds;  bus1.cpu_lds = lds;
    bus1.cpu_addr = addr;  bus1.cpu_dout = data;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput($sformatf("%s.cpu0", tag),
                {bus0.cpu_din, bus0.cpu_dtack, bus0.cpu_berr, bus0.ram_cs, bus0.ram_we_u, bus0.ram_we_l}, 32'h0);
    checkOutput($sformatf("%s.ram0", tag), {bus0.ram_din, 2'b00, bus0.ram_addr}, 32'h0);
    checkOutput($sformatf("%s.cpu1", tag),
                {bus1.cpu_din, bus1.cpu_dtack, bus1.cpu_berr, bus1.ram_cs, bus1.ram_we_u, bus1.ram_we_l}, 32'h0);
    checkOutput($sformatf("%s.ram1", tag), {bus1.ram_din, 2'b00, bus1.ram_addr}, 32'h0);
  endtask

  // One complete CPU bus cycle; hold = extra cycles AS stays high after acknowledge.
  task automatic applyStimulus(input logic rw, input logic uds, input logic lds,
                               input logic [22:0] addr, input logic [15:0] data, input int hold);
    int          offs [2];
    bit          hit [2];
    int          dtackFirst [2], berrFirst [2], dtackCnt [2], berrCnt [2], csCnt [2];
    logic [31:0] seenAddr [2], seenWe [2], seenDin [2];
    logic        sCs [2], sDt [2], sBe [2];
    logic [31:0] sAd [2], sWe [2], sRd [2];
    int          lat;
    int          last;
    int          word;

    for (int d = 0; d < 2; d++) begin
      offs[d] = (int'({addr, 1'b0}) - int'(d == 0 ? BASE0 : BASE1) + 32'h100_0000) % 32'h100_0000;
      hit[d]  = offs[d] < 2 * DEPTH;
      dtackFirst[d] = NONE;  berrFirst[d] = NONE;
      dtackCnt[d] = 0;  berrCnt[d] = 0;  csCnt[d] = 0;
      seenAddr[d] = '1;  seenWe[d] = '1;  seenDin[d] = '1;
    end
    last = 4 + hold;

    @(negedge clk);
    setCpu(1'b1, rw, uds, lds, addr, data);
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      #1;
      sCs[0] = bus0.ram_cs;  sDt[0] = bus0.cpu_dtack;  sBe[0] = bus0.cpu_berr;
      sAd[0] = 32'(bus0.ram_addr);  sWe[0] = {30'h0, bus0.ram_we_u, bus0.ram_we_l};  sRd[0] = 32'(bus0.ram_din);
      sCs[1] = bus1.ram_cs;  sDt[1] = bus1.cpu_dtack;  sBe[1] = bus1.cpu_berr;
      sAd[1] = 32'(bus1.ram_addr);  sWe[1] = {30'h0, bus1.ram_we_u, bus1.ram_we_l};  sRd[1] = 32'(bus1.ram_din);
      for (int d = 0; d < 2; d++) begin
        if (sCs[d]) begin
          if (csCnt[d] == 0) begin
            seenAddr[d] = sAd[d];  seenWe[d] = sWe[d];  seenDin[d] = sRd[d];
          end
          csCnt[d]++;
        end
        if (sDt[d]) begin
          if (dtackFirst[d] == NONE) dtackFirst[d] = k;
          dtackCnt[d]++;
        end
        if (sBe[d]) begin
          if (berrFirst[d] == NONE) berrFirst[d] = k;
          berrCnt[d]++;
        end
      end
      // Once the access is latched, the remaining CPU inputs must not matter.
      if (k == 0) setCpu(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 23'($urandom), 16'($urandom));
    end

    @(negedge clk);
    setCpu(1'b0, 1'b1, 1'b0, 1'b0, 23'h0, 16'h0);
    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      word = offs[d] / 2;
      lat  = rw ? 3 : 2;
      if (hit[d]) begin
        if (rw) lastDin[d] = refMem[d][word];
        else begin
          if (uds) refMem[d][word][15:8] = data[15:8];
          if (lds) refMem[d][word][7:0]  = data[7:0];
        end
      end
      checkOutput($sformatf("dtackLat%0d", d), dtackFirst[d], hit[d] ? lat : NONE);
      checkOutput($sformatf("berrLat%0d", d), berrFirst[d], hit[d] ? NONE : 1);
      checkOutput($sformatf("dtackCnt%0d", d), dtackCnt[d], hit[d] ? last - lat + 1 : 0);
      checkOutput($sformatf("berrCnt%0d", d), berrCnt[d], hit[d] ? 0 : last);
      checkOutput($sformatf("csCnt%0d", d), csCnt[d], hit[d] ? 1 : 0);
      if (hit[d]) begin
        checkOutput($sformatf("ramAddr%0d", d), seenAddr[d], 32'(word));
        checkOutput($sformatf("ramWe%0d", d), seenWe[d], rw ? 32'h0 : {30'h0, uds, lds});
        if (!rw) checkOutput($sformatf("ramDin%0d", d), seenDin[d], 32'(data));
      end
    end
    checkOutput("drop0", {bus0.cpu_dtack, bus0.cpu_berr, bus0.ram_cs}, 32'h0);
    checkOutput("drop1", {bus1.cpu_dtack, bus1.cpu_berr, bus1.ram_cs}, 32'h0);
    checkOutput("cpuDin0", bus0.cpu_din, lastDin[0]);
    checkOutput("cpuDin1", bus1.cpu_din, lastDin[1]);
  endtask

  // Reset lands on the edge that would leave WAIT for a read in DUT0's window.
  task automatic resetInWait();
    @(negedge clk);
    setCpu(1'b1, 1'b1, 1'b1, 1'b1, 23'd5, 16'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("resetWait");
    @(negedge clk);
    reset = 1'b0;
    setCpu(1'b0, 1'b1, 1'b0, 1'b0, 23'h0, 16'h0);
    lastDin[0] = 16'h0;
    lastDin[1] = 16'h0;
    @(posedge clk);
    #1;
    checkOutput("postReset0", {bus0.cpu_dtack, bus0.cpu_berr, bus0.ram_cs}, 32'h0);
    checkOutput("postReset1", {bus1.cpu_dtack, bus1.cpu_berr, bus1.ram_cs}, 32'h0);
  endtask

  initial begin
    logic [23:0] byteAddr;
    int          sel;
    int          hold;

    for (int i = 0; i < DEPTH; i++) begin
      bankU0[i] = 8'h0;  bankL0[i] = 8'h0;  bankU1[i] = 8'h0;  bankL1[i] = 8'h0;
      refMem[0][i] = 16'h0;  refMem[1][i] = 16'h0;
    end
    lastDin[0] = 16'h0;
    lastDin[1] = 16'h0;
    reset = 1'b1;
    setCpu(1'b0, 1'b1, 1'b0, 1'b0, 23'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(1'b0, 1'b1, 1'b1, 23'd5, 16'hBEEF, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 23'd5, 16'h0000, 0);
    checkOutput("wordRead", bus0.cpu_din, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 1'b1, 23'd5, 16'h1234, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 23'd5, 16'h0000, 0);
    checkOutput("byteRead", bus0.cpu_din, 16'hBE34);
    applyStimulus(1'b1, 1'b1, 1'b1, 23'h084000, 16'h0000, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 23'd5, 16'h0000, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 23'd5, 16'hFFFF, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 23'h07FFFF, 16'hA5A5, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 23'h083FFF, 16'h5A5A, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 23'h083FFF, 16'h0000, 0);

    resetInWait();
    applyStimulus(1'b1, 1'b1, 1'b1, 23'd5, 16'h0000, 0);
    checkOutput("readAfterReset", bus0.cpu_din, 16'hBE34);

    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1:    byteAddr = BASE0 + 24'(2 * $urandom_range(0, 15));
        2, 3:    byteAddr = BASE1 + 24'(2 * $urandom_range(0, 15));
        4:       byteAddr = ($urandom_range(0, 1) == 1 ? BASE1 : BASE0)
                            + 24'(2 * DEPTH) - 24'(2 * $urandom_range(0, 1));
        default: byteAddr = 24'($urandom);
      endcase
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), byteAddr[23:1], 16'($urandom), hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ram_bus_ctrl.md
RAM_BUS_CTRL -- requirements
Module: ram_bus_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 24'h000000: byte address of the first RAM word in CPU space.
REQ-002 SHALL have parameter DEPTH, default 16384: number of 16-bit words in the RAM window.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default $clog2(DEPTH): RAM word address width.
REQ-004 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 SHALL have clk  input  1  rising-edge clock.
REQ-006 SHALL have reset  input  1  synchronous active-high reset.
REQ-007 SHALL have cpu_as  input  1  address strobe (active-high), level held for the whole bus cycle.
REQ-008 SHALL have cpu_rw  input  1  1 = read, 0 = write.
REQ-009 SHALL have cpu_uds, cpu_lds  input  1 each  upper (D15:8) and lower (D7:0) byte strobes.
REQ-010 SHALL have cpu_addr  input  23  word address A23:A1.
REQ-011 SHALL have cpu_dout  input  16  CPU write data.
REQ-012 SHALL have cpu_din  output  16  registered read data to CPU.
REQ-013 SHALL have cpu_dtack  output  1  registered data-transfer acknowledge.
REQ-014 SHALL have cpu_berr  output  1  registered bus error for out-of-window accesses.
REQ-015 SHALL have ram_cs  output  1  chip select to both byte banks.
REQ-016 SHALL have ram_we_u, ram_we_l  output  1 each  write enables, upper and lower byte banks.
REQ-017 SHALL have ram_addr  output  ADDRESS_WIDTH  word address to both banks.
REQ-018 SHALL have ram_din  output  16  write data {upper, lower}.
REQ-019 SHALL have ram_q  input  16  bank read data {upper, lower}, valid one clock after the address edge.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK, ERR.
REQ-021 IDLE: on an edge with cpu_as=1, SHALL latch cpu_addr, cpu_rw, cpu_uds, cpu_lds, cpu_dout.
REQ-022 IDLE: on that edge, SHALL go to ISSUE if {cpu_addr,1'b0} - BASE_ADDR < 2*DEPTH (unsigned), else to ERR.
REQ-023 ram_addr SHALL be the low ADDRESS_WIDTH bits of (latched byte address - BASE_ADDR) >> 1.
REQ-024 ISSUE (exactly one cycle): ram_cs=1; for writes, ram_we_u=uds and ram_we_l=lds; ram_din=latched data.
REQ-025 ISSUE SHALL go to WAIT for reads and to ACK for writes.
REQ-026 WAIT (one cycle, ram_cs=0) SHALL register ram_q into cpu_din and go to ACK.
REQ-027 ram_cs, ram_we_u and ram_we_l SHALL be 0 in every state except ISSUE.
REQ-028 ACK: cpu_dtack=1; SHALL hold until cpu_as=0 is sampled, then go to IDLE.
REQ-029 ERR: cpu_berr=1, no RAM access; SHALL hold until cpu_as=0, then go to IDLE.
REQ-030 Latency, AS sampled at edge N: read dtack=1 from edge N+3; write dtack=1 from edge N+2; berr=1 from edge N+1.
REQ-031 A write with both strobes 0 SHALL still be acknowledged, with ram_we_u=ram_we_l=0.
REQ-032 A read SHALL return the full 16-bit word regardless of strobes; cpu_din SHALL be held until the next read.
REQ-033 Changes to cpu inputs after the IDLE latch edge SHALL be ignored until return to IDLE.
REQ-034 cpu_as held high continuously SHALL NOT start a second access; a new access requires one low sample first.
REQ-035 Address window arithmetic SHALL be 24-bit unsigned; an address below BASE_ADDR SHALL wrap to a large value and be treated as out of range.

Reset
REQ-036 On reset, in any state: state=IDLE; cpu_din=0, cpu_dtack=0, cpu_berr=0, ram_cs=0, ram_we_u=0, ram_we_l=0, ram_addr=0, ram_din=0.
REQ-037 Reset mid-operation (ISSUE/WAIT/ACK/ERR) SHALL abort without any RAM write in the reset cycle.
REQ-038 After reset deasserts, the first access SHALL start only on a cpu_as=1 sample in IDLE.

Verification
REQ-039 Word write then read: BASE=0, write 16'hBEEF at word 5 with uds=lds=1 -> ram_we_u=ram_we_l=1 for one cycle, ram_addr=5, dtack at N+2; read word 5 -> cpu_din=16'hBEEF, dtack at N+3.
REQ-040 Byte write: write 16'h12_34, lds only, over 16'hBEEF -> ram_we_l=1, ram_we_u=0; readback = 16'hBE34.
REQ-041 Out of window: BASE=24'h100000, DEPTH=16384, access byte 24'h108000 -> berr=1 at N+1, ram_cs never high, dtack=0; berr drops the cycle after as=0.
REQ-042 Held AS: keep cpu_as=1 for 10 cycles after dtack -> exactly one ram_cs pulse; dtack stays 1 until as=0.
REQ-043 Reset in WAIT: assert reset during read WAIT -> next edge all outputs 0, state IDLE; subsequent read completes normally.
